// File: rtl/process_host_pkg.sv
// Shared state encoding, status-word layout and default sizing for the processing-slave host.
package process_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    SETTLE,
    POLL,
    DONE
  } state_t;

  localparam int AW = 11;

  // Status word: {rsvd[31:25], ready[24], maxpos[23:16], maxval[15:0]}
  localparam int READY_BIT  = 24;
  localparam int MAXPOS_LSB = 16;
  localparam int MAXVAL_MSB = 15;

  localparam int DEF_IMG_WORDS   = 12;
  localparam int DEF_GAUSS_WORDS = 2;
  localparam int DEF_STATUS_ADDR = 14;
  localparam int DEF_POLL_GAP    = 4;
  localparam int DEF_MAX_POLLS   = 256;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/process_host_avm_single_xfer.sv
// Single Avalon-MM transfer: drives one read or write and flags the accept cycle.
// Latency: combinational; accept in the cycle the slave drops waitrequest.
// Backpressure: the caller holds req/addr/data stable until accept.
module avm_single_xfer
  import process_pkg::*;
(
  input  logic          wr_req,
  input  logic          rd_req,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          accept,
  output logic [31:0]   rdata,
  output logic [AW-1:0] avm_address,
  output logic          avm_write,
  output logic          avm_read,
  output logic [3:0]    avm_byteenable,
  output logic [31:0]   avm_writedata,
  input  logic [31:0]   avm_readdata,
  input  logic          avm_waitrequest
);

  logic active;

  // A read request never coexists with a write; write wins if a caller ever breaks that.
  assign avm_write      = wr_req;
  assign avm_read       = rd_req & ~wr_req;
  assign active         = avm_write | avm_read;
  assign avm_byteenable = active ? 4'b1111 : 4'b0000;
  assign avm_address    = addr;
  assign avm_writedata  = wdata;
  assign accept         = active & ~avm_waitrequest;
  assign rdata          = avm_readdata;

endmodule

// File: rtl/process_host.sv
// Avalon-MM host: streams image+Gaussian words into the slave, polls status, returns maxval/maxpos.
// Latency: 2 cycles per word with a zero-wait slave; res_valid 1 cycle after the accepted status read.
// Backpressure: one word buffered; in_ready only while no write is pending; strobes held through waitrequest.
module process_host
  import process_pkg::*;
#(
  parameter int IMG_WORDS   = DEF_IMG_WORDS,
  parameter int GAUSS_WORDS = DEF_GAUSS_WORDS,
  parameter int STATUS_ADDR = DEF_STATUS_ADDR,
  parameter int POLL_GAP    = DEF_POLL_GAP,
  parameter int MAX_POLLS   = DEF_MAX_POLLS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [31:0]   in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          busy,
  output logic          res_valid,
  output logic [15:0]   res_maxval,
  output logic [7:0]    res_maxpos,
  output logic          error,
  output logic [AW-1:0] avm_address,
  output logic          avm_write,
  output logic          avm_read,
  output logic [3:0]    avm_byteenable,
  output logic [31:0]   avm_writedata,
  input  logic [31:0]   avm_readdata,
  input  logic          avm_waitrequest
);

  localparam int TOTAL = IMG_WORDS + GAUSS_WORDS;
  localparam int WCW   = cnt_width(TOTAL);
  localparam int PCW   = cnt_width(MAX_POLLS);
  localparam int GCW   = cnt_width(POLL_GAP);

  state_t          state, state_nx;
  logic [WCW-1:0]  wcnt;
  logic [PCW-1:0]  pcnt;
  logic [GCW-1:0]  gcnt;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic            err_q;

  logic            wr_req, rd_req, xfer_acc;
  logic [AW-1:0]   xfer_addr;
  logic [31:0]     rdata;
  logic            last_word, ready_hit, polls_spent, gap_done;

  assign last_word   = (wcnt == WCW'(TOTAL - 1));
  assign ready_hit   = rdata[READY_BIT];
  assign polls_spent = (pcnt == PCW'(MAX_POLLS - 1));
  assign gap_done    = (gcnt <= GCW'(1));
  assign xfer_addr   = (state == POLL) ? AW'(STATUS_ADDR) : addr_q;

  wire unused_rsvd = ^rdata[31:READY_BIT+1];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = LOAD;
      LOAD:   if (in_valid) state_nx = WRITE;
      WRITE:  if (xfer_acc) state_nx = last_word ? SETTLE : LOAD;
      SETTLE: if (gap_done) state_nx = POLL;
      POLL:   if (xfer_acc) state_nx = (ready_hit || polls_spent) ? DONE : SETTLE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD);
    busy      = (state != IDLE);
    wr_req    = (state == WRITE);
    rd_req    = (state == POLL);
    res_valid = (state == DONE) && !err_q;
    error     = (state == DONE) && err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt       <= '0;
      pcnt       <= '0;
      gcnt       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      res_maxval <= '0;
      res_maxpos <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          wcnt  <= '0;
          pcnt  <= '0;
          err_q <= 1'b0;
        end
        LOAD: if (in_valid) begin
          wdata_q <= in_data;
          addr_q  <= AW'(wcnt);
        end
        WRITE: if (xfer_acc) begin
          if (last_word) gcnt <= GCW'(POLL_GAP);
          else           wcnt <= wcnt + 1'b1;
        end
        SETTLE: if (!gap_done) gcnt <= gcnt - 1'b1;
        POLL: if (xfer_acc) begin
          if (ready_hit) begin
            res_maxval <= rdata[MAXVAL_MSB:0];
            res_maxpos <= rdata[MAXPOS_LSB+7:MAXPOS_LSB];
          end else begin
            pcnt <= pcnt + 1'b1;
            // Gap is reloaded before every retry so a stale ready flag is never sampled.
            if (polls_spent) err_q <= 1'b1;
            else             gcnt  <= GCW'(POLL_GAP);
          end
        end
        default: ;
      endcase
    end
  end

  avm_single_xfer u_xfer (
    .wr_req          (wr_req),
    .rd_req          (rd_req),
    .addr            (xfer_addr),
    .wdata           (wdata_q),
    .accept          (xfer_acc),
    .rdata           (rdata),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_read        (avm_read),
    .avm_byteenable  (avm_byteenable),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest)
  );

endmodule
